// File: rtl/lfsr_pkg.sv
// Shared definitions for the Fibonacci LFSR generator and its receive-side checker.
// The feedback equation lives here so both ends always agree on it.
package lfsr_pkg;

   localparam int LFSR_WIDTH = 5;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lfsr_state_t;

   // Arguments are zero-extended to 32 bits so any LFSR width up to 32 can share it.
   function automatic logic lfsr_parity(input logic [31:0] taps, input logic [31:0] state);
      return ^(taps & state);
   endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: self-synchronises to a Fibonacci LFSR stream, then flywheels on its
// own prediction and counts mismatched bits.
//
// state  | meaning
// SEARCH | filling history with WIDTH received bits
// VERIFY | history loaded; waiting for LOCK_COUNT consecutive correct predictions
// LOCKED | predicting every bit, counting beats and mismatches
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int WIDTH       = LFSR_WIDTH,
   parameter int LOCK_COUNT  = 8,
   parameter int LOSS_THRESH = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reinit,
   input  logic             valid,
   input  logic             in_bit,
   input  logic [WIDTH-1:0] taps,
   input  logic             clear_counts,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count,
   output logic [WIDTH-1:0] pred_state
);

   localparam int FILL_W  = $clog2(WIDTH) + 1;
   localparam int MATCH_W = $clog2(LOCK_COUNT) + 1;
   localparam int MISS_W  = $clog2(LOSS_THRESH) + 1;

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

   lfsr_state_t        state, state_next;
   logic [WIDTH-1:0]   h, h_next;
   logic [FILL_W-1:0]  fill, fill_next;
   logic [MATCH_W-1:0] match, match_next;
   logic [MISS_W-1:0]  miss, miss_next;
   logic [MATCH_W-1:0] run, run_next;
   logic               pred, mismatch, beat;
   logic               locked_next, err_next, bit_inc;

   assign beat     = valid & ~reinit;
   assign pred     = lfsr_parity(32'(taps), 32'(h));
   assign mismatch = in_bit ^ pred;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SEARCH;
         h         <= '0;
         fill      <= '0;
         match     <= '0;
         miss      <= '0;
         run       <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_next;
         h         <= h_next;
         fill      <= fill_next;
         match     <= match_next;
         miss      <= miss_next;
         run       <= run_next;
         locked    <= locked_next;
         err_pulse <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      h_next     = h;
      fill_next  = fill;
      match_next = match;
      miss_next  = miss;
      run_next   = run;
      if (reinit) begin
         state_next = SEARCH;
         h_next     = '0;
         fill_next  = '0;
         match_next = '0;
         miss_next  = '0;
         run_next   = '0;
      end else if (valid) begin
         case (state)
            SEARCH: begin
               h_next    = {h[WIDTH-2:0], in_bit};
               fill_next = fill + 1'b1;
               if (fill == FILL_LAST) begin
                  state_next = VERIFY;
                  match_next = '0;
               end
            end
            VERIFY: begin
               h_next = {h[WIDTH-2:0], in_bit};
               if (mismatch) begin
                  match_next = '0;
               end else if ((h != '0) && (taps != '0)) begin
                  // An all-zero history or tap mask predicts trivially; it must not lock.
                  match_next = match + 1'b1;
                  if (match == MATCH_LAST) begin
                     state_next = LOCKED;
                     miss_next  = '0;
                     run_next   = '0;
                  end
               end
            end
            LOCKED: begin
               // Flywheel on the prediction so one corrupted bit is counted only once.
               h_next = {h[WIDTH-2:0], pred};
               if (mismatch) begin
                  run_next = '0;
                  if (miss == MISS_LAST) begin
                     state_next = SEARCH;
                     fill_next  = '0;
                     miss_next  = '0;
                  end else begin
                     miss_next = miss + 1'b1;
                  end
               end else if (run == MATCH_LAST) begin
                  run_next  = '0;
                  miss_next = '0;
               end else begin
                  run_next = run + 1'b1;
               end
            end
            default: state_next = SEARCH;
         endcase
      end
   end

   always_comb begin
      locked_next = (state_next == LOCKED);
      err_next    = beat & (state == LOCKED) & mismatch;
      bit_inc     = beat & (state == LOCKED);
   end

   sat_counter #(.W(CNT_W)) u_err_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear_counts),
      .inc   (err_next),
      .count (err_count)
   );

   sat_counter #(.W(CNT_W)) u_bit_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear_counts),
      .inc   (bit_inc),
      .count (bit_count)
   );

   assign pred_state = h;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker driven by a taps=10010 generator seeded 00001.
module tb_lfsr_checker;

   localparam int W  = 5;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst, reinit, valid, in_bit, clear_counts;
   logic [W-1:0]  taps;
   logic          locked, err_pulse;
   logic [CW-1:0] err_count, bit_count;
   logic [W-1:0]  pred_state;

   logic [W-1:0]  g;
   int            tests  = 0;
   int            failed = 0;
   int            pulses;
   logic          seen;

   lfsr_checker dut (
      .clk          (clk),
      .rst          (rst),
      .reinit       (reinit),
      .valid        (valid),
      .in_bit       (in_bit),
      .taps         (taps),
      .clear_counts (clear_counts),
      .locked       (locked),
      .err_pulse    (err_pulse),
      .err_count    (err_count),
      .bit_count    (bit_count),
      .pred_state   (pred_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are applied at a negedge; outputs are observed at the following negedge.
   task automatic step(input logic v, input logic b);
      valid  = v;
      in_bit = b;
      @(negedge clk);
      valid        = 1'b0;
      reinit       = 1'b0;
      clear_counts = 1'b0;
   endtask

   task automatic gen_beat(input logic flip);
      logic fb;
      fb = ^(taps & g);
      g  = {g[W-2:0], fb};
      step(1'b1, fb ^ flip);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; reinit = 1'b0; valid = 1'b0; in_bit = 1'b0; clear_counts = 1'b0;
      taps = 5'b10010; g = 5'b00001;
      @(negedge clk);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_err_pulse", 32'(err_pulse), 0);
      chk("rst_err_count", 32'(err_count), 0);
      chk("rst_bit_count", 32'(bit_count), 0);
      chk("rst_pred_state", 32'(pred_state), 0);
      rst = 1'b0;

      // Lock: 5 fill beats + 8 matches
      for (int i = 0; i < 12; i++) gen_beat(1'b0);
      chk("lock_beat12", 32'(locked), 0);
      gen_beat(1'b0);
      chk("lock_beat13", 32'(locked), 1);
      chk("lock_bit_count", 32'(bit_count), 0);
      chk("lock_pred_state", 32'(pred_state), 32'(g));
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         gen_beat(1'b0);
         pulses += int'(err_pulse);
      end
      chk("clean_pulses", 32'(pulses), 0);
      chk("clean_err_count", 32'(err_count), 0);
      chk("clean_bit_count", 32'(bit_count), 100);

      // Single bit error
      gen_beat(1'b1);
      chk("single_pulse", 32'(err_pulse), 1);
      chk("single_err_count", 32'(err_count), 1);
      chk("single_locked", 32'(locked), 1);
      step(1'b0, 1'b0);
      chk("single_pulse_gone", 32'(err_pulse), 0);
      for (int i = 0; i < 31; i++) gen_beat(1'b0);
      chk("single_after_err", 32'(err_count), 1);
      chk("single_after_locked", 32'(locked), 1);
      chk("single_bit_count", 32'(bit_count), 132);

      // clear_counts, alone and together with an error beat
      clear_counts = 1'b1;
      step(1'b0, 1'b0);
      chk("clear_err_count", 32'(err_count), 0);
      chk("clear_bit_count", 32'(bit_count), 0);
      clear_counts = 1'b1;
      gen_beat(1'b1);
      chk("clear_err_pulse", 32'(err_pulse), 1);
      chk("clear_err_wins", 32'(err_count), 0);
      chk("clear_bit_wins", 32'(bit_count), 0);
      for (int i = 0; i < 8; i++) gen_beat(1'b0);
      clear_counts = 1'b1;
      step(1'b0, 1'b0);

      // Loss of lock after 4 consecutive errors, then re-lock
      for (int i = 0; i < 3; i++) gen_beat(1'b1);
      chk("loss_after3", 32'(locked), 1);
      gen_beat(1'b1);
      chk("loss_after4", 32'(locked), 0);
      chk("loss_err_count", 32'(err_count), 4);
      chk("loss_bit_count", 32'(bit_count), 4);
      for (int i = 0; i < 12; i++) gen_beat(1'b0);
      chk("relock_beat12", 32'(locked), 0);
      gen_beat(1'b0);
      chk("relock_beat13", 32'(locked), 1);

      // reinit with a simultaneous (erroneous) beat
      reinit = 1'b1;
      gen_beat(1'b1);
      chk("reinit_locked", 32'(locked), 0);
      chk("reinit_pulse", 32'(err_pulse), 0);
      chk("reinit_err_count", 32'(err_count), 4);
      chk("reinit_bit_count", 32'(bit_count), 4);

      // Asynchronous reset while in VERIFY
      for (int i = 0; i < 7; i++) gen_beat(1'b0);
      chk("verify_locked", 32'(locked), 0);
      chk("verify_pred_state", 32'(pred_state), 32'(g));
      #2 rst = 1'b1;
      #1;
      chk("arst_pred_state", 32'(pred_state), 0);
      chk("arst_err_count", 32'(err_count), 0);
      chk("arst_bit_count", 32'(bit_count), 0);
      chk("arst_locked", 32'(locked), 0);
      @(negedge clk);
      rst = 1'b0;

      // Random valid gaps: same lock beat and counts
      g = 5'b00001;
      for (int i = 1; i <= 13; i++) begin
         repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
         gen_beat(1'b0);
         if (i == 12) chk("gaps_beat12", 32'(locked), 0);
      end
      chk("gaps_beat13", 32'(locked), 1);
      for (int i = 0; i < 100; i++) begin
         repeat ($urandom_range(0, 1)) step(1'b0, 1'b0);
         gen_beat(1'b0);
      end
      chk("gaps_err_count", 32'(err_count), 0);
      chk("gaps_bit_count", 32'(bit_count), 100);

      // Lockup stream: all zeros
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 1'b0);
         seen = seen | locked;
      end
      chk("zeros_never_locked", 32'(seen), 0);

      // Zero tap mask with a random stream
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      taps = '0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)));
         seen = seen | locked;
      end
      chk("notaps_never_locked", 32'(seen), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's Fibonacci LFSR generator.
- Takes the generator's serial output one bit per valid beat and self-synchronises to it by loading its history from received bits.
- Verifies lock, then predicts every following bit and counts mismatches.
- Used as the PRBS error checker at the far end of serial test links and loopbacks.

Parameters:
- WIDTH, 5, LFSR length in bits; must match the generator.
- LOCK_COUNT, 8, consecutive correct predictions required to declare lock.
- LOSS_THRESH, 4, mismatches without an intervening clean run of LOCK_COUNT that force loss of lock.
- CNT_W, 16, width of the error and bit counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reinit  in  1  synchronous restart of synchronisation; counters kept.
- valid  in  1  in_bit is a new stream bit this cycle (counterpart of the generator's advance).
- in_bit  in  1  received serial bit (the generator's out).
- taps  in  WIDTH  feedback tap mask; bit i selects history bit i; quasi-static.
- clear_counts  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse on a mismatched beat while LOCKED.
- err_count  out  CNT_W  saturating count of mismatches while LOCKED.
- bit_count  out  CNT_W  saturating count of valid beats while LOCKED.
- pred_state  out  WIDTH  current history/state register, for debug.

Behaviour:
- Generator model
  - Generator state S: next state = {S[WIDTH-2:0], fb}, fb = XOR of (taps & S), output bit = fb.
  - Hence S[i] equals the bit received i+1 beats ago.
  - Checker keeps history h[WIDTH-1:0] as a shift register: on each accepted bit x, h <= {h[WIDTH-2:0], x}.
  - Prediction p = reduction-XOR(taps & h), computed combinationally from the current h.
- Beats: only cycles with valid=1 are beats; with valid=0 all state holds.
- Reset: rst=1 asynchronously sets state=SEARCH, h=0, fill and match counters 0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- State SEARCH
  - Each beat shifts in_bit into h and increments fill.
  - After WIDTH beats go to VERIFY with match=0.
- State VERIFY
  - Each beat shifts in_bit into h.
  - in_bit==p and h!=0 and taps!=0: match++.
  - in_bit==p but h==0 or taps==0 (stuck/lockup stream): match held, no lock progress.
  - in_bit!=p: match=0 and stay in VERIFY (history is already refreshed by the shift).
  - When match reaches LOCK_COUNT, go to LOCKED with miss=0 and run=0.
  - locked rises in the cycle after the completing beat.
- State LOCKED
  - Each beat shifts p, not in_bit, into h (flywheel: one bit error is counted once).
  - bit_count++ (saturating).
  - Mismatch: err_pulse=1 in the next cycle, err_count++ (saturating at all-ones), miss++, run=0.
  - Match: run++; when run reaches LOCK_COUNT, miss=0.
  - When miss reaches LOSS_THRESH: go to SEARCH with fill=0; locked falls in the next cycle.
  - The beat that triggers loss is still counted in err_count.
- All outputs are registered; err_pulse is high for exactly one cycle per erroneous beat.
- Precedence: rst > reinit > beat processing.
  - reinit=1: state=SEARCH, h=0, fill/match/miss/run=0, locked=0 next cycle; any simultaneous beat is discarded.
  - clear_counts concurrent with an error beat: the counters become 0, and err_pulse still fires.
- Width rules
  - Counters saturate and never wrap.
  - fill, match, miss and run are sized with $clog2 of their limit +1.
- taps change while LOCKED: no special handling; the resulting mismatches drive normal loss of lock.

Decomposition:
- Shared package lfsr_pkg holds:
  - the state enum typedef (SEARCH, VERIFY, LOCKED);
  - the default WIDTH;
  - a function lfsr_parity(taps, state) returning the feedback bit.
- The generator and this checker both use lfsr_parity so the feedback equation is defined once.
- Natural sub-module: sat_counter (parameterised width, inc, clr, saturating), instantiated for err_count and bit_count.

Test Plan:
- Lock: rst, taps=5'b10010, drive the generator's 31-bit maximal sequence from seed 5'b00001, one bit per beat → locked=1 in the cycle after beat 13 (5 fill + 8 matches); err_count=0 after 100 further beats; bit_count=100.
- Single error: once locked, invert one bit → err_pulse high exactly one cycle, err_count=1, locked stays 1, the next 31 beats give no further errors.
- Loss: once locked, invert 4 consecutive bits → err_count=4, locked=0 in the cycle after the 4th; the clean stream then re-locks after 13 more beats.
- Lockup stream: feed all zeros for 50 beats (and separately taps=0 with a random stream) → locked never asserts.
- Gaps: random valid=0 cycles interleaved (50% duty) → same lock beat index and counts as the gap-free run.
- Controls: assert reinit mid-LOCKED together with a valid beat → locked=0 next cycle, beat ignored, err_count preserved. Assert rst asynchronously mid-VERIFY → all outputs 0 immediately. clear_counts → err_count=bit_count=0.
